instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 PCSrc  input  1  redirect select: 0 = sequential, 1 = branch target; sampled only on accept cycle.
REQ-006 branch_target  input  32  redirect PC (PC + imm from Adder2).
REQ-007 stall  input  1  downstream backpressure; instruction accepted when instr_valid=1 and stall=0.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address; equals pc.
REQ-010 imem_gnt  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  read data valid; arrives at least 1 cycle after gnt.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-014 instr  output  32  registered fetched instruction.
REQ-015 instr_pc  output  32  address of instr.
REQ-016 pc_plus4  output  32  pc + 4, combinational, feeds execute stage.
REQ-017 fetch_err  output  1  sticky misaligned-redirect error.
REQ-018 fetch_count  output  32  count of accepted instructions.

Function
REQ-019 pc register, 32 bits; pc_plus4 = pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-020 FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR.
REQ-021 S_IDLE: imem_req=0; unconditional transition to S_REQ next cycle.
REQ-022 S_REQ: imem_req=1, imem_addr=pc; imem_req held high until imem_gnt=1; on gnt -> S_WAIT.
REQ-023 S_WAIT: imem_req=0; on imem_rvalid=1 capture instr<=imem_rdata, instr_pc<=pc, instr_valid<=1 -> S_HOLD; otherwise remain.
REQ-024 imem_rvalid in any state other than S_WAIT is ignored; no output changes.
REQ-025 S_HOLD: instr_valid=1; instr/instr_pc stable while stall=1, for any number of cycles.
REQ-026 Accept (S_HOLD, stall=0): pc <= PCSrc ? branch_target : pc_plus4; instr_valid<=0; fetch_count += 1 (wraps at 2^32); -> S_REQ.
REQ-027 PCSrc/branch_target outside an accept cycle have no effect.
REQ-028 Accept with PCSrc=1 and branch_target[1:0] != 2'b00: pc unchanged, fetch_err<=1, fetch_count still increments, -> S_ERR.
REQ-029 S_ERR: imem_req=0, instr_valid=0, fetch_err=1; exit only by reset.
REQ-030 Minimum latency: gnt in first S_REQ cycle, rvalid the following cycle -> instr_valid high 2 cycles after S_REQ entry; back-to-back throughput 1 instruction per 3 cycles.
REQ-031 imem_addr[1:0] is always 2'b00.

Reset
REQ-032 rst_n=0 at a rising edge, in any state: state<=S_IDLE, pc<=RESET_PC, instr<=0, instr_pc<=0, instr_valid<=0, fetch_err<=0, fetch_count<=0; imem_req=0.
REQ-033 Reset mid-transaction (S_REQ or S_WAIT) abandons the request; a late imem_rvalid arriving in S_IDLE or the first subsequent S_REQ is discarded.
REQ-034 First request after reset release: imem_req=1 with imem_addr=RESET_PC, 1 cycle after release (S_IDLE then S_REQ).

Verification
REQ-035 Reset, gnt immediate, rvalid next cycle with 32'h0000_0013, stall=0, PCSrc=0 -> instr=32'h13, instr_pc=0; next imem_addr=32'h4; fetch_count=1.
REQ-036 Accept with PCSrc=1, branch_target=32'h0000_0100 -> next imem_addr=32'h100, instr_pc of next instruction=32'h100.
REQ-037 stall=1 for 5 cycles in S_HOLD, PCSrc toggled meanwhile -> instr/instr_pc unchanged, no imem_req; after release next address = pc_plus4.
REQ-038 imem_gnt withheld 4 cycles -> imem_req and imem_addr constant for all 4 cycles; spurious rvalid in S_REQ ignored.
REQ-039 Accept with PCSrc=1, branch_target=32'h0000_0102 -> fetch_err=1, imem_req stays 0, instr_valid=0 until rst_n=0.
REQ-040 RESET_PC=32'hFFFF_FFFC, sequential accept -> next imem_addr=32'h0; rst_n=0 during S_WAIT then rvalid -> instr_valid stays 0, first fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps the program counter and issues one
// instruction-memory request at a time. It holds each fetched word until
// the downstream stage accepts it, then moves to pc+4 or to the branch target.
//
// Handshakes:
//   imem side : a request is offered while imem_req=1 and is transferred on a
//               rising edge where imem_req=1 and imem_gnt=1. Read data is taken
//               on the first imem_rvalid=1 after the grant. imem_rvalid is
//               ignored at any other time.
//   downstream: an instruction is offered while instr_valid=1 and is accepted
//               on a rising edge where instr_valid=1 and stall=0.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [31:0] fetch_count,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        fetch_err_q;
    logic [31:0] fetch_count_q;
    logic        imem_req_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] pc_next_d;
    logic        redirect_bad_d;

    // Next-PC selection; only consulted on an accept edge.
    always_comb begin
        pc_plus4_d     = pc_q + 32'd4;
        redirect_bad_d = PCSrc && (branch_target[1:0] != 2'b00);
        pc_next_d      = PCSrc ? branch_target : pc_plus4_d;
    end

    // Fetch sequencer: state, PC, captured instruction and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= 32'h0;
            imem_req_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_REQ;
                    imem_req_q <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        state_q    <= S_WAIT;
                        imem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_valid_q <= 1'b0;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        if (redirect_bad_d) begin
                            // Misaligned target: keep pc and park until reset.
                            fetch_err_q <= 1'b1;
                            state_q     <= S_ERR;
                        end else begin
                            pc_q       <= pc_next_d;
                            imem_req_q <= 1'b1;
                            state_q    <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q    <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign fetch_err   = fetch_err_q;
    assign fetch_count = fetch_count_q;
    assign dbg_state_o = state_q;

endmodule
